// File: rtl/ifetch_biu_if.sv
// Instruction-fetch handshake bundle between the core fetch unit (master) and
// the fetch bus interface unit (slave).
interface ifetch_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic          req_vld;
  logic          req_rdy;
  logic [AW-1:0] req_pc;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic [DW-1:0] rsp_ir;

  modport slave (
    input  req_vld, req_pc, rsp_rdy,
    output req_rdy, rsp_vld, rsp_ir
  );

  modport master (
    output req_vld, req_pc, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_ir
  );
endinterface

// File: rtl/ifetch_biu.sv
// Fetch responder: issues reads to a fixed-latency instruction memory and returns words
// in order through a credit-protected FIFO. Define IFETCH_BIU_PERF_CNT_EN for stall/fetch counters.
module ifetch_biu #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1,
  parameter int DEPTH  = 2
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_if.slave       ifetch,
  output logic          mem_en,
  output logic [AW-3:0] mem_addr,
  input  logic [DW-1:0] mem_rdata
`ifdef IFETCH_BIU_PERF_CNT_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   fetch_cnt
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              accept;
  logic              push;
  logic              pop;
  logic              fifo_full;

  logic [RD_LAT-1:0] pipe_vld_reg;
  logic [RD_LAT-1:0] pipe_vld_next;
  logic [CW-1:0]     inflight_reg;
  logic [CW-1:0]     inflight_next;
  logic [CW-1:0]     fifo_cnt_reg;
  logic [CW-1:0]     fifo_cnt_next;
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     wr_ptr_next;
  logic [PW-1:0]     rd_ptr_reg;
  logic [PW-1:0]     rd_ptr_next;
  logic              req_rdy_reg;
  logic              req_rdy_next;
  logic              rsp_vld_reg;
  logic [DW-1:0]     rsp_ir_reg;
  logic [DW-1:0]     head_next;
  logic [DW-1:0]     fifo_mem [DEPTH];
  logic              unused_pc_lsb;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign accept        = ifetch.req_vld & req_rdy_reg;
  assign push          = pipe_vld_reg[RD_LAT-1];
  assign pop           = rsp_vld_reg & ifetch.rsp_rdy;
  assign fifo_full     = (fifo_cnt_reg == CW'(DEPTH));
  assign unused_pc_lsb = ^ifetch.req_pc[1:0];

  assign mem_en   = accept;
  assign mem_addr = accept ? ifetch.req_pc[AW-1:2] : '0;

  assign ifetch.req_rdy = req_rdy_reg;
  assign ifetch.rsp_vld = rsp_vld_reg;
  assign ifetch.rsp_ir  = rsp_ir_reg;

  // Read-valid shift register: stage RD_LAT-1 lines up with mem_rdata.
  assign pipe_vld_next[0] = accept;
  generate
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_pipe
      assign pipe_vld_next[gi] = pipe_vld_reg[gi-1];
    end
  endgenerate

  always_comb begin
    inflight_next = inflight_reg;
    case ({accept, push})
      2'b10:   inflight_next = inflight_reg + CW'(1);
      2'b01:   inflight_next = inflight_reg - CW'(1);
      default: inflight_next = inflight_reg;
    endcase

    fifo_cnt_next = fifo_cnt_reg;
    case ({push, pop})
      2'b10:   fifo_cnt_next = fifo_cnt_reg + CW'(1);
      2'b01:   fifo_cnt_next = fifo_cnt_reg - CW'(1);
      default: fifo_cnt_next = fifo_cnt_reg;
    endcase

    wr_ptr_next = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    rd_ptr_next = pop  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;

    // A word written this cycle is not yet in the array, so forward it when it becomes the head.
    head_next = (push && (wr_ptr_reg == rd_ptr_next)) ? mem_rdata : fifo_mem[rd_ptr_next];

    // Ready is a pure function of next-state credit, never of req_vld/rsp_rdy directly.
    req_rdy_next = (({1'b0, inflight_next} + {1'b0, fifo_cnt_next}) < (CW+1)'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_reg <= '0;
      inflight_reg <= '0;
      fifo_cnt_reg <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      req_rdy_reg  <= 1'b0;
      rsp_vld_reg  <= 1'b0;
      rsp_ir_reg   <= '0;
    end else begin
      pipe_vld_reg <= pipe_vld_next;
      inflight_reg <= inflight_next;
      fifo_cnt_reg <= fifo_cnt_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      req_rdy_reg  <= req_rdy_next;
      rsp_vld_reg  <= (fifo_cnt_next != '0);
      if (fifo_cnt_next != '0) begin
        rsp_ir_reg <= head_next;
      end
    end
  end

`ifdef IFETCH_BIU_PERF_CNT_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] fetch_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      fetch_cnt_reg <= '0;
    end else begin
      if (ifetch.req_vld && !req_rdy_reg) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      if (accept) begin
        fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign fetch_cnt = fetch_cnt_reg;
`endif

`ifndef SYNTHESIS
  // Credit accounting guarantees a free slot for every returning read.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));
`endif

endmodule

// File: tb/tb_ifetch_biu.sv
// Randomized scoreboard bench for ifetch_biu with directed fetch, credit, hold and reset scenarios.
module tb_ifetch_biu;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_en;
  logic [AW-3:0] mem_addr;
  logic [DW-1:0] mem_rdata;
`ifdef IFETCH_BIU_PERF_CNT_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   fetch_cnt;
`endif

  ifetch_if #(.AW(AW), .DW(DW)) ifetch ();

  ifetch_biu #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ifetch    (ifetch),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
`ifdef IFETCH_BIU_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .fetch_cnt (fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Instruction memory contents and a fixed-latency read model.
  logic [31:0] mem_arr [256];
  logic [31:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    rd_pipe[0] <= mem_en ? mem_arr[mem_addr[7:0]] : 32'hDEAD_BEEF;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  // Reference model: a fetch accepted in cycle c is visible from cycle c+RD_LAT+1 until popped.
  typedef struct {
    logic [31:0] data;
    int          avail;
  } exp_t;
  exp_t exp_q[$];

  int   cyc = 0;
  int   acc_cnt = 0;
  int   pop_cnt = 0;
  logic armed = 1'b0;
  logic exp_rdy, exp_acc;
  logic [31:0] stall_exp = 0;
  logic [31:0] fetch_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) armed <= 1'b0;
    else     armed <= 1'b1;
  end

  // Request side: credit, strobe and address checks; pushes expected responses.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_cnt   = 0;
      stall_exp = 0;
      fetch_exp = 0;
    end else begin
      exp_rdy = armed && ((acc_cnt - pop_cnt) < DEPTH);
      exp_acc = ifetch.req_vld && exp_rdy;
      check("req_rdy", 64'(ifetch.req_rdy), 64'(exp_rdy));
      check("mem_en", 64'(mem_en), 64'(exp_acc));
      check("mem_addr", 64'(mem_addr), exp_acc ? 64'(ifetch.req_pc[31:2]) : 64'd0);
`ifdef IFETCH_BIU_PERF_CNT_EN
      check("stall_cnt", 64'(stall_cnt), 64'(stall_exp));
      check("fetch_cnt", 64'(fetch_cnt), 64'(fetch_exp));
`endif
      if (exp_acc) begin
        exp_q.push_back('{data: mem_arr[ifetch.req_pc[9:2]], avail: cyc + RD_LAT + 1});
        acc_cnt++;
        fetch_exp = fetch_exp + 32'd1;
      end
      if (ifetch.req_vld && !exp_rdy) stall_exp = stall_exp + 32'd1;
    end
  end

  // Response monitor: pops and compares whenever a response is due or presented.
  logic mon_vld;
  always @(negedge clk) begin
    if (rst) begin
      pop_cnt <= 0;
    end else begin
      mon_vld = (exp_q.size() != 0) && (cyc >= exp_q[0].avail);
      check("rsp_vld", 64'(ifetch.rsp_vld), 64'(mon_vld));
      if (mon_vld) begin
        check("rsp_ir", 64'(ifetch.rsp_ir), 64'(exp_q[0].data));
        if (ifetch.rsp_rdy) begin
          $display("rsp pop data=0x%08h cyc=%0d", exp_q[0].data, cyc);
          void'(exp_q.pop_front());
          pop_cnt <= pop_cnt + 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard;
    ifetch.req_vld = 1'b0;
    ifetch.rsp_rdy = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      step();
      guard++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_rdy"}, 64'(ifetch.req_rdy), 64'd0);
    check({tag, "_rsp_vld"}, 64'(ifetch.rsp_vld), 64'd0);
    check({tag, "_rsp_ir"},  64'(ifetch.rsp_ir),  64'd0);
    check({tag, "_mem_en"},  64'(mem_en),         64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr),      64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int n_acc;
    int i;
    int guard;
    logic [31:0] held_ir;

    for (int k = 0; k < 256; k++) mem_arr[k] = $urandom;
    for (int k = 0; k < 4; k++) mem_arr[k] = 32'hA0 + k;
    mem_arr[4] = 32'h0000_0013;

    ifetch.req_vld = 1'b0;
    ifetch.req_pc  = '0;
    ifetch.rsp_rdy = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    step();
    rst = 1'b0;
    step();

    // Single fetch: PC 0x10 -> word 4 -> 0x13
    ifetch.req_vld = 1'b1;
    ifetch.req_pc  = 32'h0000_0010;
    ifetch.rsp_rdy = 1'b1;
    @(negedge clk);
    check("t1_mem_en", 64'(mem_en), 64'd1);
    check("t1_mem_addr", 64'(mem_addr), 64'h4);
    step();
    ifetch.req_vld = 1'b0;
    @(negedge clk);
    check("t1_rsp_early", 64'(ifetch.rsp_vld), 64'd0);
    step();
    @(negedge clk);
    check("t1_rsp_vld", 64'(ifetch.rsp_vld), 64'd1);
    check("t1_rsp_ir", 64'(ifetch.rsp_ir), 64'h13);
    step();
    @(negedge clk);
    check("t1_popped", 64'(ifetch.rsp_vld), 64'd0);
    drain();

    // Streaming 0x0..0xC, data 0xA0..0xA3 in order (monitor checks order)
    i = 0;
    guard = 0;
    while (i < 4 && guard < 40) begin
      ifetch.req_vld = 1'b1;
      ifetch.req_pc  = 32'(i * 4);
      @(negedge clk);
      n_acc = int'(ifetch.req_rdy);
      step();
      i += n_acc;
      guard++;
    end
    check("t2_all_issued", 64'(i), 64'd4);
    drain();

    // Credit exhaustion
    ifetch.rsp_rdy = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 6; c++) begin
      ifetch.req_vld = 1'b1;
      ifetch.req_pc  = $urandom;
      @(negedge clk);
      if (ifetch.req_rdy) n_acc++;
      step();
    end
    check("t3_accepts", 64'(n_acc), 64'd2);
    @(negedge clk);
    check("t3_rdy_low", 64'(ifetch.req_rdy), 64'd0);
    step();
    ifetch.rsp_rdy = 1'b1;
    @(negedge clk);
    step();
    ifetch.rsp_rdy = 1'b0;
    @(negedge clk);
    check("t3_rdy_back", 64'(ifetch.req_rdy), 64'd1);
    step();
    ifetch.req_vld = 1'b0;

    // Hold stability for 5 cycles with rsp_rdy low
    held_ir = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) held_ir = ifetch.rsp_ir;
      check("t4_hold_vld", 64'(ifetch.rsp_vld), 64'd1);
      check("t4_hold_ir", 64'(ifetch.rsp_ir), 64'(held_ir));
      step();
    end
    drain();

    // Reset one cycle after an accept
    ifetch.req_vld = 1'b1;
    ifetch.req_pc  = $urandom;
    ifetch.rsp_rdy = 1'b1;
    @(posedge clk);
    #1;
    ifetch.req_vld = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("t5");
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("t5_no_rsp", 64'(ifetch.rsp_vld), 64'd0);
      step();
    end

    // Misaligned PC plus blocked cycles
    ifetch.req_vld = 1'b1;
    ifetch.req_pc  = 32'h0000_0002;
    ifetch.rsp_rdy = 1'b0;
    @(negedge clk);
    check("t6_mem_addr", 64'(mem_addr), 64'h0);
    repeat (5) step();
    drain();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      ifetch.req_vld = ($urandom_range(0, 9) < 7);
      ifetch.req_pc  = $urandom;
      ifetch.rsp_rdy = ($urandom_range(0, 9) < 6);
      step();
    end
    drain();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
